// File: rtl/gost_pkg.sv
// Shared definitions for the GOST 28147-89 round sequencer.
// Contents:
//   WORD_W, NROUNDS  - half-block width and round count (both fixed at 32)
//   state_t          - sequencer states ST_IDLE / ST_RUN / ST_DONE
//   key_idx()        - subkey index for a round counter value and direction
package gost_pkg;

  localparam int WORD_W  = 32;
  localparam int NROUNDS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Encrypt walks K0..K7 three times and then K7..K0.
  // Decrypt walks K0..K7 once and then K7..K0 three times.
  // The reversed stretch starts at round 24 for encrypt and at round 8 for decrypt.
  function automatic logic [2:0] key_idx(input logic [4:0] cnt, input logic decrypt);
    logic rev;
    if (decrypt) begin
      rev = (cnt >= 5'd8);
    end else begin
      rev = (cnt >= 5'd24);
    end
    if (rev) begin
      key_idx = 3'd7 - cnt[2:0];
    end else begin
      key_idx = cnt[2:0];
    end
  endfunction

endpackage

// File: rtl/gost_key_sched.sv
// Combinational subkey selector.
// Ports:
//   i_cnt     in  5    round counter
//   i_decrypt in  1    1 = decrypt key order
//   i_key     in  256  key; Kj = i_key[32j+31:32j]
//   o_subkey  out 32   selected subkey
module gost_key_sched
  import gost_pkg::*;
(
  input  logic [4:0]        i_cnt,
  input  logic              i_decrypt,
  input  logic [255:0]      i_key,
  output logic [WORD_W-1:0] o_subkey
);

  logic [2:0] w_idx;

  assign w_idx = key_idx(i_cnt, i_decrypt);

  // Word select: the index is scaled by 32 to address the key bit vector.
  assign o_subkey = i_key[{w_idx, 5'd0} +: WORD_W];

endmodule

// File: rtl/gost_round_ctrl.sv
// GOST 28147-89 round sequencer.
// Runs 32 rounds over an external combinational round function, at one round per clock.
// The module holds the N1/N2 state and selects the subkey for each round.
// A start/valid/ready handshake connects it to the cipher-mode logic.
//
// Optional feature: define GOST_DECRYPT_EN to add the idecrypt input.
//   idecrypt is latched when a block is accepted and selects the decrypt key order.
//   Without the macro, only the encrypt key order is built.
//
// Ports:
//   iclk, irst   clock, synchronous active-high reset
//   istart       load iblock; taken in IDLE, or in DONE together with iready
//   iblock[63:0] input block, [31:0]=N1, [63:32]=N2
//   ikey[255:0]  key, must stay stable while obusy=1
//   idecrypt     (GOST_DECRYPT_EN only) decrypt key order for this block
//   ornd_n1      N1 operand to the round function (0 outside RUN)
//   ornd_key     current subkey to the round function (0 outside RUN)
//   irnd_f       round function result, same cycle
//   obusy        high from accept until the result is consumed
//   ovalid       oblock valid, held until iready
//   oblock[63:0] result, [31:0]=N1, [63:32]=N2
//   iready       consumer takes oblock
module gost_round_ctrl
  import gost_pkg::*;
(
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic [63:0]       iblock,
  input  logic [255:0]      ikey,
`ifdef GOST_DECRYPT_EN
  input  logic              idecrypt,
`endif
  output logic [WORD_W-1:0] ornd_n1,
  output logic [WORD_W-1:0] ornd_key,
  input  logic [WORD_W-1:0] irnd_f,
  output logic              obusy,
  output logic              ovalid,
  output logic [63:0]       oblock,
  input  logic              iready
);

  localparam logic [4:0] LAST_RND = 5'(NROUNDS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_cnt;
  logic [4:0]        w_cnt_nxt;
  logic [WORD_W-1:0] r_n1;
  logic [WORD_W-1:0] r_n2;
  logic [WORD_W-1:0] w_n1_nxt;
  logic [WORD_W-1:0] w_n2_nxt;
  logic              r_dec;
  logic              w_dec_nxt;
  logic              w_dec_in;
  logic              r_busy;
  logic              r_valid;
  logic [63:0]       r_oblock;
  logic [WORD_W-1:0] w_subkey;
  logic              w_run;

`ifdef GOST_DECRYPT_EN
  assign w_dec_in = idecrypt;
`else
  assign w_dec_in = 1'b0;
`endif

  gost_key_sched u_key_sched (
    .i_cnt     (r_cnt),
    .i_decrypt (r_dec),
    .i_key     (ikey),
    .o_subkey  (w_subkey)
  );

  assign w_run    = (r_state == ST_RUN);
  assign ornd_n1  = w_run ? r_n1 : {WORD_W{1'b0}};
  assign ornd_key = w_run ? w_subkey : {WORD_W{1'b0}};
  assign obusy    = r_busy;
  assign ovalid   = r_valid;
  assign oblock   = r_oblock;

  // Next-state logic, round datapath and block load.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_n1_nxt    = r_n1;
    w_n2_nxt    = r_n2;
    w_dec_nxt   = r_dec;
    case (r_state)
      ST_IDLE: begin
        if (istart) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 5'd0;
          w_n1_nxt    = iblock[31:0];
          w_n2_nxt    = iblock[63:32];
          w_dec_nxt   = w_dec_in;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The last round keeps the halves in place (no swap).
        if (r_cnt == LAST_RND) begin
          w_n2_nxt    = r_n2 ^ irnd_f;
          w_state_nxt = ST_DONE;
        end else begin
          w_n1_nxt  = r_n2 ^ irnd_f;
          w_n2_nxt  = r_n1;
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      ST_DONE: begin
        if (iready) begin
          // Back-to-back case: the result is consumed and the next block is loaded on the same edge.
          if (istart) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 5'd0;
            w_n1_nxt    = iblock[31:0];
            w_n2_nxt    = iblock[63:32];
            w_dec_nxt   = w_dec_in;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and half-block registers.
  // The output registers are loaded from next-state values so they line up with r_state.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_n1     <= {WORD_W{1'b0}};
      r_n2     <= {WORD_W{1'b0}};
      r_dec    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_oblock <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_n1     <= w_n1_nxt;
      r_n2     <= w_n2_nxt;
      r_dec    <= w_dec_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_valid  <= (w_state_nxt == ST_DONE);
      r_oblock <= (w_state_nxt == ST_DONE) ? {w_n2_nxt, w_n1_nxt} : 64'd0;
    end
  end

endmodule
